// File: rtl/registro_io_in.sv
// registro_io_in: memory-mapped input port with pin synchronizer, W1C change flags and maskable irq
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   pins_i[WIDTH]       asynchronous external pins
//   sel_i, rd_i, wr_i   IO bus select and strobes
//   addr_i[2]           0 DATA (ro), 1 CHANGE (w1c), 2 MASK, 3 reserved
//   DATA_i, DATA_o      bus write data / combinational read data (0 when not reading)
//   irq_o               registered |(change & mask)
module registro_io_in #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pins_i,
  input  logic             sel_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      DATA_i,
  output logic [31:0]      DATA_o,
  output logic             irq_o
);
  logic [WIDTH-1:0] s [SYNC_STAGES];
  logic [WIDTH-1:0] data_reg, chg_reg, mask_reg, clr;
  logic             we;
  assign we  = sel_i & wr_i;
  assign clr = (we && addr_i == 2'd1) ? DATA_i[WIDTH-1:0] : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) s[k] <= '0;
      data_reg <= '0;
      chg_reg  <= '0;
      mask_reg <= '0;
      irq_o    <= 1'b0;
    end else begin
      s[0] <= pins_i;
      for (int k = 1; k < SYNC_STAGES; k++) s[k] <= s[k-1];
      data_reg <= s[SYNC_STAGES-1];
      // new edges are OR-ed in after the clear so a colliding edge is never lost
      chg_reg  <= (chg_reg & ~clr) | (s[SYNC_STAGES-1] ^ data_reg);
      if (we && addr_i == 2'd2) mask_reg <= DATA_i[WIDTH-1:0];
      irq_o    <= |(chg_reg & mask_reg);
    end
  end
  always_comb
    DATA_o = !(sel_i && rd_i) ? '0 :
             addr_i == 2'd0   ? 32'(data_reg) :
             addr_i == 2'd1   ? 32'(chg_reg) :
             addr_i == 2'd2   ? 32'(mask_reg) : '0;
endmodule

// File: tb/tb_registro_io_in.sv
// tb_registro_io_in: scoreboard bench for registro_io_in with directed vectors
module tb_registro_io_in;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pins_i;
  logic        sel_i, rd_i, wr_i;
  logic [1:0]  addr_i;
  logic [31:0] DATA_i, DATA_o;
  logic        irq_o;
  logic        mon_v;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    string       name;
    logic [31:0] data;
    bit          ci;
    logic        irq;
  } exp_t;
  exp_t q[$];
  registro_io_in #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pins_i(pins_i), .sel_i(sel_i), .rd_i(rd_i),
    .wr_i(wr_i), .addr_i(addr_i), .DATA_i(DATA_i), .DATA_o(DATA_o), .irq_o(irq_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (mon_v) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output presented with no expected entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (DATA_o !== e.data) begin
          errors++;
          $display("FAIL %s: DATA_o=%h expected %h", e.name, DATA_o, e.data);
        end
        if (e.ci) begin
          checks++;
          if (irq_o !== e.irq) begin
            errors++;
            $display("FAIL %s_irq: irq_o=%b expected %b", e.name, irq_o, e.irq);
          end
        end
      end
    end
  end
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle();
    sel_i = 0; rd_i = 0; wr_i = 0; mon_v = 0; addr_i = 0; DATA_i = 0;
  endtask
  task automatic acc(input bit s, input bit r, input bit w, input logic [1:0] a,
                     input logic [31:0] d, input bit chk, input logic [31:0] exp,
                     input bit ci, input logic irq, input string name);
    exp_t e;
    sel_i = s; rd_i = r; wr_i = w; addr_i = a; DATA_i = d; mon_v = chk;
    if (chk) begin
      e.name = name; e.data = exp; e.ci = ci; e.irq = irq;
      q.push_back(e);
    end
    step();
    idle();
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input bit ci,
                    input logic irq, input string name);
    acc(1, 1, 0, a, 0, 1, exp, ci, irq, name);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    acc(1, 0, 1, a, d, 0, 0, 0, 0, "");
  endtask
  initial begin
    idle();
    rst_ni = 0;
    pins_i = 32'hFFFF_FFFF;
    step(); step();
    rd(0, 0, 1, 0, "rst_data");
    rd(1, 0, 1, 0, "rst_chg");
    rd(2, 0, 1, 0, "rst_mask");
    rst_ni = 1;
    rd(0, 0, 0, 0, "rel_e1");
    step();
    rd(0, 0, 0, 0, "rel_e3");
    rd(0, 32'hFFFF_FFFF, 0, 0, "rel_data");
    rd(1, 32'hFFFF_FFFF, 1, 0, "rel_chg");
    pins_i = 0;
    repeat (4) step();
    wr(1, 32'hFFFF_FFFF);
    wr(2, 32'h1);
    rd(1, 0, 1, 0, "chg_cleared");
    pins_i = 32'h5;
    step(); step();
    rd(0, 0, 0, 0, "lat_e3");
    rd(0, 32'h5, 1, 0, "lat_data");
    rd(1, 32'h5, 1, 1, "lat_irq");
    wr(1, 32'h1);
    rd(1, 32'h4, 1, 1, "w1c_irq_hold");
    rd(1, 32'h4, 1, 0, "w1c_irq_drop");
    wr(1, 32'h0);
    rd(1, 32'h4, 0, 0, "w1c_zero");
    pins_i = 32'h4;
    step(); step();
    wr(1, 32'h1);
    rd(1, 32'h5, 1, 0, "collide");
    pins_i = 32'h8000_0004;
    repeat (4) step();
    wr(1, 32'hFFFF_FFFF);
    wr(2, 32'h8000_0000);
    rd(1, 0, 1, 0, "fall_pre");
    pins_i = 32'h4;
    step(); step();
    rd(1, 0, 0, 0, "fall_e3");
    rd(1, 32'h8000_0000, 1, 0, "fall_chg");
    rd(1, 32'h8000_0000, 1, 1, "fall_irq");
    wr(2, 0);
    rd(1, 32'h8000_0000, 1, 1, "unmask_hold");
    rd(1, 32'h8000_0000, 1, 0, "unmask_drop");
    acc(0, 1, 0, 0, 0, 1, 0, 0, 0, "rd_nosel");
    acc(1, 0, 0, 0, 0, 1, 0, 0, 0, "sel_nord");
    rd(3, 0, 0, 0, "addr3");
    wr(0, 32'h1234);
    rd(0, 32'h4, 0, 0, "ro_data");
    acc(0, 0, 1, 2, 32'hAA, 0, 0, 0, 0, "");
    rd(2, 0, 0, 0, "wr_nosel");
    wr(2, 32'h0F);
    acc(1, 1, 1, 2, 32'hF0, 1, 32'h0F, 0, 0, "rdwr_pre");
    rd(2, 32'hF0, 0, 0, "rdwr_post");
    step(); step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
